// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants and FSM state type for the time-shared multiplier.
// Imported by mult_share_arbiter and its partial-product unit.
package mult_share_arbiter_pkg;

  localparam int PROD_W = 128;
  localparam int OP_W   = 64;
  localparam int HALF_W = 32;
  localparam int PP_W   = HALF_W + OP_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_SUM,
    S_RSP
  } state_t;

endpackage

// File: rtl/mult_32x64_lut6_akak.sv
// Combinational 32x64 unsigned partial-product unit.
// Ports: a_half (32b), b (64b) in; pp (96b) = a_half*b out.
module mult_32x64_lut6_akak
  import mult_share_arbiter_pkg::*;
(
  input  logic [HALF_W-1:0] a_half,
  input  logic [OP_W-1:0]   b,
  output logic [PP_W-1:0]   pp
);

  assign pp = PP_W'(a_half) * PP_W'(b);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter in front of one 64x64 multiplier built from
// two passes of a shared 32x64 unit.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_a/req_b
// per requester; rsp_valid/rsp_ready/rsp_id/rsp_prod; busy.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_a,
  input  logic [N_REQ*OP_W-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [PROD_W-1:0]     rsp_prod,
  output logic                  busy
);

  state_t state_q;
  state_t state_d;

  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   rr_nxt;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   g_q;
  logic              gnt_any;
  logic              take;
  logic [OP_W-1:0]   a_sel;
  logic [OP_W-1:0]   b_sel;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [HALF_W-1:0] a_half;
  logic [PP_W-1:0]   pp;
  logic [PP_W-1:0]   pp_q;
  logic [PROD_W-1:0] acc_q;
  int                idx;

  // Walk from the highest offset down so the requester
  // closest to rr_q is the one left in gnt_id.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        a_sel = req_a[i*OP_W +: OP_W];
        b_sel = req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    if (int'(gnt_id) == N_REQ - 1) begin
      rr_nxt = '0;
    end else begin
      rr_nxt = gnt_id + ID_W'(1);
    end
  end

  assign take = (state_q == S_IDLE) && gnt_any && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (gnt_any) state_d = S_HI;
      S_HI:   state_d = S_LO;
      S_LO:   state_d = S_SUM;
      S_SUM:  state_d = S_RSP;
      S_RSP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = take && (gnt_id == ID_W'(i));
    end
    rsp_valid = (state_q == S_RSP);
    busy      = (state_q != S_IDLE);
    a_half    = (state_q == S_HI) ?
                a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
  end

  assign rsp_id   = g_q;
  assign rsp_prod = acc_q;

  mult_32x64_lut6_akak u_pp (
    .a_half (a_half),
    .b      (b_q),
    .pp     (pp)
  );

  // HI pass result is shifted up by 32 when LO starts;
  // the LO pass result is added in SUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      g_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      pp_q  <= '0;
      acc_q <= '0;
    end else begin
      if (take) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        g_q  <= gnt_id;
        rr_q <= rr_nxt;
      end
      if (state_q == S_HI || state_q == S_LO) begin
        pp_q <= pp;
      end
      if (state_q == S_LO) begin
        acc_q <= {pp_q, HALF_W'(0)};
      end
      if (state_q == S_SUM) begin
        acc_q <= acc_q + PROD_W'(pp_q);
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed cases
// followed by random traffic against a behavioural model.
module tb_mult_share_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [127:0]   rsp_prod;
  logic           busy;

  int checks = 0;
  int errors = 0;

  int           m_rr;
  int           m_age;
  int           m_id;
  logic [127:0] m_prod;
  int           m_rsps;
  int           obs_hs;
  int           g;
  int           ix;
  logic [N-1:0] exp_rdy;

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mul(input logic [63:0] a,
                                       input logic [63:0] b);
    return {64'b0, a} * {64'b0, b};
  endfunction

  function automatic logic [127:0] gold(input int i);
    return mul(req_a[i*W +: W], req_b[i*W +: W]);
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return '1;
      1: return 64'($urandom_range(0, 15));
      2: return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_op(input int i,
                        input logic [63:0] a,
                        input logic [63:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Expects grant of requester gi this IDLE cycle, then the
  // response in the 4th cycle after the accept edge, held for
  // hold cycles of rsp_ready low.
  task automatic run_one(input int gi, input int hold,
                         input logic [127:0] exp);
    logic [N-1:0] oh;
    oh     = '0;
    oh[gi] = 1'b1;
    rsp_ready = (hold == 0);
    #1;
    chk("grant", req_ready, oh);
    chk("idle_busy", busy, 0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      chk("lat_valid", rsp_valid, 0);
      chk("lat_ready", req_ready, 0);
      chk("lat_busy", busy, 1);
      tick();
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, gi);
    chk("rsp_prod", rsp_prod, exp);
    for (int c = 1; c < hold; c++) begin
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_id", rsp_id, gi);
      chk("hold_prod", rsp_prod, exp);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    tick();
    tick();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready2", req_ready, 0);
    rst       = 1'b0;
    req_valid = '0;
    tick();

    set_op(0, 64'h0000_0001_0000_0002, 64'd3);
    req_valid = 4'b0001;
    run_one(0, 0, 128'h3_0000_0006);
    req_valid = '0;

    set_op(1, '1, '1);
    req_valid = 4'b0010;
    run_one(1, 0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    req_valid = '0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_op(i, {$urandom, $urandom} ^ 64'(i),
             {$urandom, $urandom} + 64'(i));
    end
    req_valid = '1;
    run_one(0, 0, gold(0));
    run_one(1, 0, gold(1));
    run_one(2, 0, gold(2));
    run_one(3, 0, gold(3));
    run_one(0, 0, gold(0));

    run_one(1, 7, gold(1));
    run_one(2, 0, gold(2));

    req_valid = 4'b0010;
    #1;
    chk("mid_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mid_no_rsp", rsp_valid, 0);
    end
    req_valid = '1;
    #1;
    chk("mid_rr_zero", req_ready, 4'b0001);
    set_op(2, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210);
    req_valid = 4'b0100;
    run_one(2, 0, mul(64'hDEAD_BEEF_0123_4567,
                      64'hFEDC_BA98_7654_3210));
    req_valid = '0;

    rst = 1'b1;
    tick();
    rst    = 1'b0;
    m_rr   = 0;
    m_age  = -1;
    m_id   = 0;
    m_prod = '0;
    m_rsps = 0;
    obs_hs = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rst       = ($urandom_range(0, 399) == 0);
      req_valid = N'($urandom) & N'($urandom | $urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        set_op(i, rnd64(), rnd64());
      end
      #1;
      g = -1;
      if (m_age < 0 && !rst) begin
        for (int k = 0; k < N; k++) begin
          ix = (m_rr + k) % N;
          if (g < 0 && req_valid[ix]) g = ix;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_onehot", $countones(req_ready) <= 1, 1);
      chk("rnd_valid", rsp_valid, m_age >= 4);
      if (m_age >= 4) begin
        chk("rnd_id", rsp_id, m_id);
        chk("rnd_prod", rsp_prod, m_prod);
      end
      if (rsp_valid && rsp_ready && !rst) obs_hs++;
      if (rst) begin
        m_age = -1;
        m_rr  = 0;
      end else if (g >= 0) begin
        m_prod = gold(g);
        m_id   = g;
        m_rr   = (g + 1) % N;
        m_age  = 1;
      end else if (m_age >= 4) begin
        if (rsp_ready) begin
          m_age = -1;
          m_rsps++;
        end
      end else if (m_age > 0) begin
        m_age++;
      end
      tick();
    end
    chk("rnd_rsp_count", obs_hs, m_rsps);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter ID_W, default $clog2(N_REQ): requester-index width.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  N_REQ  per-requester operand-pair valid.
REQ-006 req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  in  N_REQ*64  packed multiplicands; requester i uses bits [64i+63:64i].
REQ-008 req_b  in  N_REQ*64  packed multipliers; same packing as req_a.
REQ-009 rsp_valid  out  1  product available.
REQ-010 rsp_ready  in  1  consumer accepts product.
REQ-011 rsp_id  out  ID_W  index of the requester that owns rsp_prod.
REQ-012 rsp_prod  out  128  unsigned product a*b.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, HI, LO, SUM, RSP; the encoding is implementation-defined.
REQ-015 IDLE: if any req_valid is high, grant exactly one requester g by round-robin; assert req_ready[g] combinationally in the same cycle; capture a, b, and g; go to HI. Otherwise stay in IDLE.
REQ-016 Round-robin: search starts at rr_ptr and wraps from N_REQ-1 to 0; on each grant, rr_ptr <= (g+1) mod N_REQ.
REQ-017 req_ready is 0 in all states other than IDLE, and 0 for every non-granted requester.
REQ-018 HI: drive a[63:32] into the partial-product unit; pp_q <= a[63:32]*b (96 bits); go to LO.
REQ-019 LO: drive a[31:0]; pp_q <= a[31:0]*b; acc <= {pp_q,32'b0}; go to SUM.
REQ-020 SUM: acc <= acc + pp_q (128-bit, modulo 2^128, no overflow possible); go to RSP.
REQ-021 RSP: rsp_valid=1; rsp_prod=acc; rsp_id=g. If rsp_ready=1, go to IDLE next cycle; otherwise hold, with all outputs stable.
REQ-022 Latency: rsp_valid rises exactly 4 cycles after the accept edge. Minimum issue interval is 5 cycles, with rsp_ready tied high.
REQ-023 Outputs rsp_prod and rsp_id are don't-care while rsp_valid=0; they are registered, not combinational from req_*.
REQ-024 A requester that drops req_valid before it is granted is simply skipped; no state change occurs.
REQ-025 A request and a response handshake never occur in the same cycle. A new grant first occurs in the IDLE cycle following the RSP handshake.
REQ-026 Operands are unsigned; b is used at the full 64 bits in both passes.

Reset
REQ-027 On rst=1 at a clock edge: state <= IDLE, rr_ptr <= 0, rsp_valid <= 0, busy <= 0, acc <= 0, pp_q <= 0.
REQ-028 req_ready is 0 during any cycle in which rst=1.
REQ-029 Reset mid-operation, in any state including RSP with rsp_ready low, discards the in-flight product with no response.

Structure
REQ-030 The shared package holds constants PROD_W=128, OP_W=64, HALF_W=32, and the FSM state enum.
REQ-031 The single sub-module is the combinational 32x64 partial-product unit mult_32x64_lut6_akak, instantiated once and time-shared across both passes.
REQ-032 Round-robin grant logic stays inline; there is no separate arbiter sub-module.

Verification
REQ-033 Single request: req 0 with a=0x0000000100000002, b=3 -> rsp after 4 cycles, rsp_prod=0x300000006, rsp_id=0.
REQ-034 All ones: a=b=0xFFFFFFFFFFFFFFFF -> rsp_prod=0xFFFFFFFFFFFFFFFE0000000000000001.
REQ-035 Fairness: all 4 req_valid held high with distinct operands -> grant order 0,1,2,3,0. Each rsp_id matches its operands, and each product equals the golden a*b.
REQ-036 Backpressure: rsp_ready held low for 7 cycles in RSP -> rsp_valid, rsp_prod, and rsp_id are stable; req_ready stays 0; the next grant comes 1 cycle after rsp_ready rises.
REQ-037 Reset mid-operation: rst asserted in the LO state -> no rsp_valid; the next request (req 2 only) is granted and completes correctly from rr_ptr=0.
REQ-038 Random: 10k random a, b, req_valid, and rsp_ready patterns -> every product matches the model; no lost or duplicated response; req_ready is always at most one-hot.
